seq_det_param: RTL
==================

Name: seq_det_param

Overview:
Parametrised multi-symbol sequence detector, the successor to the fixed 2-bit-symbol detector. It compares a stream of SYM_W-bit symbols against a run-time programmable pattern of SEQ_LEN symbols. Overlapping or non-overlapping detection is selectable, and a saturating match counter is maintained. It sits between an input symbol source and control/status logic that consumes the match pulse and the count.

Parameters:
SYM_W, 2, symbol width in bits (>=1)
SEQ_LEN, 4, pattern length in symbols (>=2)
CNT_W, 8, match counter width (>=1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cfg_load  input  1  load pattern_in into pattern register; restarts matching
pattern_in  input  SEQ_LEN*SYM_W  pattern; first symbol expected = MSB slice [SEQ_LEN*SYM_W-1 -: SYM_W]
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every accepted symbol
in_valid  input  1  symbol qualifier
in  input  SYM_W  input symbol
clr_cnt  input  1  synchronous clear of match_cnt
match  output  1  one-cycle registered pulse per detection
fill  output  clog2(SEQ_LEN+1)  symbols currently held toward a match (0..SEQ_LEN)
match_cnt  output  CNT_W  saturating number of detections

Behaviour:
- Interface: one clock (clk). Reset (reset) is asynchronous and active-high.
- Reset: pattern register=0, history window=0, fill=0, match=0, match_cnt=0. Reset asserted mid-stream aborts any partial match immediately.
- State: pattern register P, history window H (SEQ_LEN*SYM_W bits, newest symbol in LSB slice), fill counter F.
- Accepted symbol: in_valid=1 and cfg_load=0 at a rising edge. Idle cycles (in_valid=0) leave H, F and match_cnt unchanged, and force match to 0.
- Candidate window on an accepted symbol: C = {H[(SEQ_LEN-1)*SYM_W-1:0], in}.
- Hit condition: accepted symbol, F >= SEQ_LEN-1, and C == P.
- Update on accepted symbol:
  - H <= C.
  - On a hit: match <= 1. F <= SEQ_LEN if overlap=1; F <= 0 if overlap=0. In the overlap=0 case H is still updated, but F=0 forces SEQ_LEN fresh symbols before the next hit.
  - On no hit: match <= 0; F <= min(F+1, SEQ_LEN).
- Latency: match rises at the same edge that accepts the final pattern symbol and is visible for exactly one cycle after that edge. Back-to-back hits (overlap=1) produce match high on consecutive accepted cycles.
- cfg_load=1: P <= pattern_in, F <= 0, H <= 0, match <= 0. Any simultaneous in_valid symbol is discarded; cfg_load has priority.
- match_cnt:
  - Increments by 1 on each hit; saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 sets it to 0 and takes priority over a simultaneous hit. That hit's match pulse is still produced but not counted.
  - cfg_load does not clear match_cnt.
- fill output = F, registered.
- Comparison is exact over all SEQ_LEN*SYM_W bits; there are no wildcards.
- No combinational path from inputs to outputs.

Test Plan:
1. Basic hit: reset, load pattern 8'b00_01_11_10, overlap=0. Stream 10,00,01,11,10 -> match pulses once, the cycle after the final 10; match_cnt=1; fill=0 afterwards.
2. Overlap mode: pattern 8'b10_10_10_10, overlap=1. Stream seven 10s -> match high after symbols 4,5,6,7; match_cnt=4; fill held at 4.
3. Non-overlap mode: same pattern, overlap=0. Stream eight 10s -> match only after symbols 4 and 8; match_cnt=2.
4. Gaps and reload: insert in_valid=0 cycles between symbols of test 1 -> same single hit, no match during gaps. Assert cfg_load concurrently with the third symbol -> symbol dropped, fill=0, and no hit until 4 new matching symbols arrive.
5. Counter: CNT_W=2 build, overlap=1, pattern of all 10, feed ten 10s -> match_cnt saturates at 3. Assert clr_cnt on a hit cycle -> match=1 and match_cnt=0.
6. Async reset: assert reset between clock edges with fill=3 -> fill, match, match_cnt go to 0 immediately. After release the pattern register is 0, so four 00 symbols produce a hit.

Source files
------------

// File: rtl/seq_det_param.sv
// Parametrised sequence detector: matches a stream of SYM_W-bit symbols against a
// programmable SEQ_LEN-symbol pattern, with overlap control and a saturating hit counter.
module seq_det_param #(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned SEQ_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_load,
    input  logic [SEQ_LEN*SYM_W-1:0]      pattern_in,
    input  logic                          overlap,
    input  logic                          in_valid,
    input  logic [SYM_W-1:0]              in,
    input  logic                          clr_cnt,
    output logic                          match,
    output logic [$clog2(SEQ_LEN+1)-1:0]  fill,
    output logic [CNT_W-1:0]              match_cnt
);

    localparam int unsigned PW = SEQ_LEN * SYM_W;
    localparam int unsigned HW = (SEQ_LEN - 1) * SYM_W;
    localparam int unsigned FW = $clog2(SEQ_LEN + 1);

    logic [PW-1:0]    pattern_q, pattern_d;
    // The oldest symbol of the window is never read again, so only SEQ_LEN-1 symbols are kept.
    logic [HW-1:0]    hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    cand;
    logic             hit;

    assign cand = {hist_q, in};
    assign hit  = in_valid && !cfg_load && (fill_q >= FW'(SEQ_LEN - 1)) && (cand == pattern_q);

    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_load) begin
            pattern_d = pattern_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = cand[HW-1:0];
            if (hit) begin
                match_d = 1'b1;
                fill_d  = overlap ? FW'(SEQ_LEN) : '0;
            end else if (fill_q != FW'(SEQ_LEN)) begin
                fill_d = fill_q + FW'(1);
            end
        end

        // A clear wins over a simultaneous hit; the pulse still goes out uncounted.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign match     = match_q;
    assign fill      = fill_q;
    assign match_cnt = cnt_q;

endmodule
